// File: rtl/clock_counter_gated.sv
// Gated multi-channel edge counter for slow asynchronous clocks and strobes.
// Counts selected edges per channel over a window of clk cycles, then latches results.
module clock_counter_gated #(
  parameter int NCH    = 4,
  parameter int WIDTH  = 32,
  parameter int SYNC   = 3,
  parameter int GWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       sclk,
  input  logic [1:0]           edge_mode,
  input  logic                 continuous,
  input  logic [GWIDTH-1:0]    gate_period,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 valid,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       overflow
);

  typedef enum logic {
    S_IDLE,
    S_MEASURE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NCH-1:0]    r_sync [SYNC];
  logic [NCH-1:0]    r_hist;
  logic [1:0]        r_mode;
  logic              r_cont;
  logic [GWIDTH-1:0] r_gcnt;
  logic [WIDTH-1:0]  r_acc [NCH];
  logic [NCH-1:0]    r_ovf;
  logic [NCH*WIDTH-1:0] r_count;
  logic [NCH-1:0]    r_overflow;
  logic              r_valid;

  logic [NCH-1:0]    w_rise;
  logic [NCH-1:0]    w_fall;
  logic [NCH-1:0]    w_edge;
  logic [WIDTH-1:0]  w_acc_nxt [NCH];
  logic [NCH-1:0]    w_ovf_nxt;
  logic              w_meas;
  logic              w_gp_nz;
  logic              w_start;
  logic              w_last;
  logic              w_rearm;

  // Synchroniser chain plus history flop, free running.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC; s++) begin
        r_sync[s] <= '0;
      end
      r_hist <= '0;
    end else begin
      r_sync[0] <= sclk;
      for (int s = 1; s < SYNC; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_hist <= r_sync[SYNC-1];
    end
  end

  assign w_rise = r_sync[SYNC-1] & ~r_hist;
  assign w_fall = ~r_sync[SYNC-1] & r_hist;

  always_comb begin
    w_edge = '0;
    unique case (r_mode)
      2'b00:   w_edge = w_rise;
      2'b01:   w_edge = w_fall;
      2'b10:   w_edge = w_rise | w_fall;
      default: w_edge = '0;
    endcase
  end

  assign w_meas  = (r_state == S_MEASURE);
  assign w_gp_nz = (gate_period != '0);
  assign w_start = !w_meas && start && !abort && w_gp_nz;
  assign w_last  = w_meas && !abort
                && (r_gcnt == GWIDTH'(1));
  assign w_rearm = w_last && r_cont && w_gp_nz;

  // Saturating accumulate; overflow marks an edge lost at all-ones.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_acc_nxt[i] = r_acc[i];
      w_ovf_nxt[i] = r_ovf[i];
      if (&r_acc[i]) begin
        w_ovf_nxt[i] = r_ovf[i] | w_edge[i];
      end else begin
        w_acc_nxt[i] = r_acc[i]
                     + {{(WIDTH-1){1'b0}}, w_edge[i]};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last && !w_rearm) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode <= '0;
      r_cont <= 1'b0;
      r_gcnt <= '0;
    end else if (w_start) begin
      r_mode <= edge_mode;
      r_cont <= continuous;
      r_gcnt <= gate_period;
    end else if (w_rearm) begin
      r_gcnt <= gate_period;
    end else if (w_meas && abort) begin
      r_gcnt <= '0;
    end else if (w_meas) begin
      r_gcnt <= r_gcnt - GWIDTH'(1);
    end
  end

  // Re-arm seeds zero: the final cycle's edge goes to the result only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_acc[i] <= '0;
      end
      r_ovf <= '0;
    end else if (w_start || w_rearm) begin
      for (int i = 0; i < NCH; i++) begin
        r_acc[i] <= '0;
      end
      r_ovf <= '0;
    end else if (w_meas && !abort) begin
      for (int i = 0; i < NCH; i++) begin
        r_acc[i] <= w_acc_nxt[i];
      end
      r_ovf <= w_ovf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_overflow <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_last) begin
        for (int i = 0; i < NCH; i++) begin
          r_count[i*WIDTH +: WIDTH] <= w_acc_nxt[i];
        end
        r_overflow <= w_ovf_nxt;
      end
    end
  end

  assign busy     = w_meas;
  assign valid    = r_valid;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_clock_counter_gated.sv
// Directed bench for clock_counter_gated: 32-bit and 4-bit instances
// share stimulus; expected counts derive from the generated sclk periods.
module tb_clock_counter_gated;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] sclk = '0;
  logic [1:0]     edge_mode = '0;
  logic           continuous = 1'b0;
  logic [31:0]    gate_period = '0;
  logic           start = 1'b0;
  logic           abort = 1'b0;

  logic           busy, valid;
  logic [127:0]   count;
  logic [3:0]     overflow;
  logic           busy4, valid4;
  logic [15:0]    count4;
  logic [3:0]     ovf4;

  int total = 0;
  int bad = 0;
  int div [NCH] = '{default: 0};
  int ph  [NCH] = '{default: 0};
  int ref_cnt = 0;
  logic ref_en = 1'b0;
  logic ref_prev = 1'b0;

  clock_counter_gated #(
    .NCH(4), .WIDTH(32), .SYNC(3), .GWIDTH(32)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk),
    .edge_mode(edge_mode), .continuous(continuous),
    .gate_period(gate_period), .start(start),
    .abort(abort), .busy(busy), .valid(valid),
    .count(count), .overflow(overflow)
  );

  clock_counter_gated #(
    .NCH(4), .WIDTH(4), .SYNC(3), .GWIDTH(32)
  ) u_w4 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk),
    .edge_mode(edge_mode), .continuous(continuous),
    .gate_period(gate_period), .start(start),
    .abort(abort), .busy(busy4), .valid(valid4),
    .count(count4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  // Channel i runs at clk/div[i], high for div/2 cycles; 0 holds it low.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (div[i] == 0) begin
        ph[i] = 0;
        sclk[i] = 1'b0;
      end else begin
        sclk[i] = (ph[i] < div[i] / 2);
        ph[i] = (ph[i] + 1 == div[i]) ? 0 : ph[i] + 1;
      end
    end
    if (ref_en && sclk[3] && !ref_prev) ref_cnt++;
    ref_prev = sclk[3];
  end

  task automatic chk(input string tag, input longint obs,
                     input longint exp, input longint tol = 0);
    total++;
    if (obs < exp - tol || obs > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)",
               tag, obs, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [1:0] m, input logic c,
                      input logic [31:0] gp);
    edge_mode = m;
    continuous = c;
    gate_period = gp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_window(output int nb, output logic v);
    nb = 0;
    while (busy && nb < 5000) begin
      nb++;
      tick();
    end
    v = valid;
  endtask

  int n, m, sum, vc;
  logic v;

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", |count, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    tick();

    div[0] = 10;
    repeat (20) tick();
    fire(2'b00, 1'b0, 1000);
    run_window(n, v);
    chk("t1_len", n, 1000);
    chk("t1_valid", v, 1);
    chk("t1_cnt0", count[31:0], 100, 1);
    chk("t1_others", |count[127:32], 0);
    chk("t1_ovf", overflow, 0);
    tick();
    chk("t1_pulse", valid, 0);

    div[0] = 0;
    div[1] = 4;
    repeat (20) tick();
    fire(2'b10, 1'b0, 400);
    run_window(n, v);
    chk("t2_len", n, 400);
    chk("t2_cnt1", count[63:32], 200, 1);
    fire(2'b11, 1'b0, 400);
    run_window(n, v);
    chk("t2_none_v", v, 1);
    chk("t2_none", count[63:32], 0);

    div[1] = 0;
    div[2] = 4;
    repeat (20) tick();
    fire(2'b00, 1'b0, 100);
    run_window(n, v);
    chk("t3_w4_valid", valid4, 1);
    chk("t3_w4_cnt", count4[11:8], 15);
    chk("t3_w4_ovf", ovf4[2], 1);
    chk("t3_w32_cnt", count[95:64], 25);
    chk("t3_w32_ovf", overflow[2], 0);

    fire(2'b00, 1'b0, 100);
    repeat (29) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_ab_busy", busy, 0);
    vc = valid;
    repeat (5) begin
      tick();
      vc += valid;
    end
    chk("t5_ab_nov", vc, 0);
    chk("t5_w4_hold", count4[11:8], 15);
    chk("t5_w4_ovfh", ovf4[2], 1);
    chk("t5_w32_hold", count[95:64], 25);

    fire(2'b00, 1'b0, 10);
    repeat (9) tick();
    chk("t5_pr_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_pr_nov", valid, 0);
    chk("t5_pr_idle", busy, 0);
    chk("t5_pr_hold", count[95:64], 25);

    fire(2'b00, 1'b0, 0);
    chk("t5_gp0", busy, 0);
    tick();
    chk("t5_gp0b", busy, 0);

    fire(2'b00, 1'b0, 20);
    run_window(n, v);
    chk("t3b_len", n, 20);
    chk("t3b_w4_cnt", count4[11:8], 5);
    chk("t3b_w4_ovf", ovf4[2], 0);

    div[2] = 0;
    div[3] = 5;
    repeat (20) tick();
    ref_cnt = 0;
    ref_en = 1'b1;
    fire(2'b00, 1'b1, 50);
    sum = 0;
    for (int w = 0; w < 10; w++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!valid && n < 200);
      chk("t4_gap", n, 50);
      sum += int'(count[127:96]);
      if (w == 8) gate_period = 0;
      if (w < 9) chk("t4_busy", busy, 1);
    end
    ref_en = 1'b0;
    chk("t4_end_idle", busy, 0);
    chk("t4_last", count[127:96], 10);
    chk("t4_sum", sum, ref_cnt, 1);

    div[3] = 0;
    div[0] = 10;
    repeat (10) tick();
    fire(2'b00, 1'b0, 100);
    repeat (50) tick();
    reset_n = 1'b0;
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_valid", valid, 0);
    chk("t6_count", |count, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_busy4", busy4, 0);
    chk("t6_count4", |count4, 0);
    reset_n = 1'b1;
    tick();

    fire(2'b00, 1'b0, 30);
    repeat (9) tick();
    gate_period = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_window(m, v);
    chk("t6_len", 10 + m, 30);
    chk("t6_valid2", v, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
